// File: rtl/block_data_memory_if.sv
// Block memory bus: the cache's MEM_* busywait request/response signals.
// The cache (master) raises READ or WRITE with an address and data, holds
// them while BUSYWAIT is high, and samples READ_DATA once BUSYWAIT drops.
interface block_data_memory_if;
  logic         READ;
  logic         WRITE;
  logic [27:0]  BLOCK_ADDR;
  logic [127:0] WRITE_DATA;
  logic         BUSYWAIT;
  logic [127:0] READ_DATA;

  modport master (
    output READ,
    output WRITE,
    output BLOCK_ADDR,
    output WRITE_DATA,
    input  BUSYWAIT,
    input  READ_DATA
  );

  modport slave (
    input  READ,
    input  WRITE,
    input  BLOCK_ADDR,
    input  WRITE_DATA,
    output BUSYWAIT,
    output READ_DATA
  );
endinterface

// File: rtl/block_data_memory.sv
// Block-granular data memory behind the data cache. Accepts one 128-bit
// block read or write at a time, waits a fixed LATENCY, performs the array
// access, then spends one ACK cycle with BUSYWAIT low before taking the next
// request. Write has priority when READ and WRITE arrive together.
module block_data_memory #(
  parameter int DEPTH_BLOCKS = 256,
  parameter int IDX_BITS     = 8,
  parameter int LATENCY      = 4
) (
  input logic                CLK,
  input logic                RESET,
  block_data_memory_if.slave bus
);

  // Down-counter width; at least one bit even when LATENCY is 1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_write;
  logic [IDX_BITS-1:0] r_idx;
  logic [127:0]       r_wdata;
  logic [127:0]       r_read_data;
  logic [127:0]       r_mem [DEPTH_BLOCKS];

  logic               w_accept;
  logic               w_write_now;
  logic               w_busy;

  // Upper address bits are deliberately ignored so that blocks alias.
  logic [27-IDX_BITS:0] w_unused_addr;
  assign w_unused_addr = bus.BLOCK_ADDR[27:IDX_BITS];

  assign w_accept    = (r_state == ST_IDLE) && (bus.READ || bus.WRITE);
  assign w_write_now = (r_state == ST_BUSY) && (r_cnt == CNT_ZERO) && r_is_write;

  // BUSYWAIT rises in the same cycle a request appears so the cache never
  // sees a stale "done" on its first edge in a request state.
  always_comb begin
    w_busy = 1'b0;
    if (RESET) begin
      w_busy = 1'b0;
    end else if (w_accept || (r_state == ST_BUSY)) begin
      w_busy = 1'b1;
    end else begin
      w_busy = 1'b0;
    end
  end

  assign bus.BUSYWAIT  = w_busy;
  assign bus.READ_DATA = r_read_data;

  // Request FSM: latch the request in IDLE, count down in BUSY, complete
  // the read into READ_DATA at count zero, then one ACK cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_is_write  <= 1'b0;
      r_idx       <= {IDX_BITS{1'b0}};
      r_wdata     <= 128'd0;
      r_read_data <= 128'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_write <= bus.WRITE;
            r_idx      <= bus.BLOCK_ADDR[IDX_BITS-1:0];
            r_wdata    <= bus.WRITE_DATA;
            r_cnt      <= CNT_LOAD;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            if (!r_is_write) begin
              r_read_data <= r_mem[r_idx];
            end
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Storage array; never cleared, and a reset during BUSY suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RESET && w_write_now) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory (LATENCY = 4). A plain array
// model of the 256 blocks plus a model of the last fetched block supply the
// expected values; stimulus is mostly randomized.
module tb_block_data_memory;
  localparam int LAT = 4;
  localparam int HI_EXP = LAT + 1;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  block_data_memory_if bus ();

  block_data_memory #(
    .DEPTH_BLOCKS(256),
    .IDX_BITS(8),
    .LATENCY(LAT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [127:0] mem_m [256];
  logic [127:0] rd_m;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a request and apply its effect to the model.
  task automatic start_req(input logic wr, input logic rd, input logic [27:0] addr,
                           input logic [127:0] data);
    bus.WRITE = wr;
    bus.READ = rd;
    bus.BLOCK_ADDR = addr;
    bus.WRITE_DATA = data;
    if (wr) mem_m[addr[7:0]] = data;
    else if (rd) rd_m = mem_m[addr[7:0]];
  endtask

  // Count cycles with BUSYWAIT high until the ACK cycle, then release the
  // request on the edge leaving ACK. Optionally scramble address/data after
  // acceptance.
  task automatic wait_done(input bit scramble, output int hi);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus.BUSYWAIT !== 1'b1) break;
      hi++;
      if (scramble && hi > 1) begin
        bus.BLOCK_ADDR = 28'($urandom());
        bus.WRITE_DATA = rand128();
      end
    end
    @(posedge CLK);
    #1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  task automatic test_init();
    int hi;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      start_req(1'b1, 1'b0, 28'(i), rand128());
      wait_done(1'b0, hi);
      if (hi != HI_EXP) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL init_latency: got %0d bad writes, expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    int hi;
    RESET = 1'b1;
    bus.READ = 1'b1;
    bus.WRITE = 1'b0;
    bus.BLOCK_ADDR = 28'h0000011;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.BUSYWAIT !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.BUSYWAIT);
      else n_pass++;
      n_checks++;
      if (bus.READ_DATA !== 128'd0) $display("FAIL reset_rdata: got %h expected 0", bus.READ_DATA);
      else n_pass++;
      @(posedge CLK);
    end
    #1;
    RESET = 1'b0;
    start_req(1'b0, 1'b1, 28'h0000011, 128'd0);
    #1;
    n_checks++;
    if (bus.BUSYWAIT !== 1'b1) $display("FAIL reset_release_busy: got %b expected 1", bus.BUSYWAIT);
    else n_pass++;
    wait_done(1'b0, hi);
    n_checks++;
    if (hi != HI_EXP) $display("FAIL reset_release_latency: got %0d expected %0d", hi, HI_EXP);
    else n_pass++;
    n_checks++;
    if (bus.READ_DATA !== rd_m) $display("FAIL reset_release_rdata: got %h expected %h", bus.READ_DATA, rd_m);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int hi;
    logic [127:0] val;
    val = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE;
    start_req(1'b1, 1'b0, 28'h0000005, val);
    wait_done(1'b0, hi);
    n_checks++;
    if (hi != HI_EXP) $display("FAIL wr_latency: got %0d expected %0d", hi, HI_EXP);
    else n_pass++;
    start_req(1'b0, 1'b1, 28'h0000005, 128'd0);
    wait_done(1'b0, hi);
    n_checks++;
    if (hi != HI_EXP) $display("FAIL rd_latency: got %0d expected %0d", hi, HI_EXP);
    else n_pass++;
    n_checks++;
    if (bus.READ_DATA !== val) $display("FAIL rd_data: got %h expected %h", bus.READ_DATA, val);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int hi1;
    int hi2;
    logic [127:0] d;
    d = rand128();
    start_req(1'b1, 1'b0, 28'h0000010, d);
    wait_done(1'b0, hi1);
    start_req(1'b0, 1'b1, 28'h0000020, 128'd0);
    wait_done(1'b0, hi2);
    n_checks++;
    if (hi1 != HI_EXP) $display("FAIL b2b_wr_latency: got %0d expected %0d", hi1, HI_EXP);
    else n_pass++;
    n_checks++;
    if (hi2 != HI_EXP) $display("FAIL b2b_rd_latency: got %0d expected %0d", hi2, HI_EXP);
    else n_pass++;
    n_checks++;
    if (bus.READ_DATA !== rd_m) $display("FAIL b2b_rd_data: got %h expected %h", bus.READ_DATA, rd_m);
    else n_pass++;
    start_req(1'b0, 1'b1, 28'h0000010, 128'd0);
    wait_done(1'b0, hi1);
    n_checks++;
    if (bus.READ_DATA !== d) $display("FAIL b2b_wb_stored: got %h expected %h", bus.READ_DATA, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int hi;
    logic [127:0] old_v;
    old_v = mem_m[7];
    bus.WRITE = 1'b1;
    bus.READ = 1'b0;
    bus.BLOCK_ADDR = 28'h0000007;
    bus.WRITE_DATA = ~old_v;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    bus.WRITE = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.BUSYWAIT !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.BUSYWAIT);
    else n_pass++;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    rd_m = 128'd0;
    @(negedge CLK);
    n_checks++;
    if (bus.BUSYWAIT !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", bus.BUSYWAIT);
    else n_pass++;
    n_checks++;
    if (bus.READ_DATA !== 128'd0) $display("FAIL midrst_rdata_clr: got %h expected 0", bus.READ_DATA);
    else n_pass++;
    @(posedge CLK);
    #1;
    start_req(1'b0, 1'b1, 28'h0000007, 128'd0);
    wait_done(1'b0, hi);
    n_checks++;
    if (bus.READ_DATA !== old_v) $display("FAIL midrst_old_kept: got %h expected %h", bus.READ_DATA, old_v);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int hi;
    logic [127:0] prior;
    start_req(1'b0, 1'b1, 28'h0000042, 128'd0);
    wait_done(1'b0, hi);
    prior = rd_m;
    start_req(1'b1, 1'b1, 28'h0000003, 128'h1);
    wait_done(1'b0, hi);
    n_checks++;
    if (hi != HI_EXP) $display("FAIL both_latency: got %0d expected %0d", hi, HI_EXP);
    else n_pass++;
    n_checks++;
    if (bus.READ_DATA !== prior) $display("FAIL both_rdata_held: got %h expected %h", bus.READ_DATA, prior);
    else n_pass++;
    start_req(1'b0, 1'b1, 28'h0000003, 128'd0);
    wait_done(1'b0, hi);
    n_checks++;
    if (bus.READ_DATA !== 128'h1) $display("FAIL both_written: got %h expected 1", bus.READ_DATA);
    else n_pass++;
  endtask

  task automatic test_alias();
    int hi;
    logic [127:0] aa;
    aa = {16{8'hAA}};
    start_req(1'b1, 1'b0, 28'h0000105, aa);
    wait_done(1'b1, hi);
    start_req(1'b0, 1'b1, 28'h0000005, 128'd0);
    wait_done(1'b1, hi);
    n_checks++;
    if (bus.READ_DATA !== aa) $display("FAIL alias_rdata: got %h expected %h", bus.READ_DATA, aa);
    else n_pass++;
  endtask

  task automatic test_random();
    int hi;
    int op;
    int gap;
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge CLK);
        #1;
      end
      op = $urandom_range(0, 2);
      start_req((op != 1) ? 1'b1 : 1'b0, (op != 0) ? 1'b1 : 1'b0,
                28'($urandom()), rand128());
      wait_done(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, hi);
      n_checks++;
      if (hi != HI_EXP) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, hi, HI_EXP);
      else n_pass++;
      n_checks++;
      if (bus.READ_DATA !== rd_m) $display("FAIL rand_rdata[%0d]: got %h expected %h", i, bus.READ_DATA, rd_m);
      else n_pass++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.BLOCK_ADDR = 28'd0;
    bus.WRITE_DATA = 128'd0;
    rd_m = 128'd0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    test_init();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_simultaneous();
    test_alias();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/block_data_memory.md
# block_data_memory

Block-granular data memory that sits behind the data cache and answers its miss traffic: 128-bit block fetches on a read miss and 128-bit write-backs on a dirty eviction. It is the responder end of the cache's `MEM_*` busywait protocol. It models a fixed, parameterised access latency so that cache stall paths are exercised.

## Interface
Parameters:
- `DEPTH_BLOCKS`, default 256: number of 128-bit blocks. Must be a power of two.
- `IDX_BITS`, default 8: equals log2(`DEPTH_BLOCKS`).
- `LATENCY`, default 4: cycles from request acceptance to the array access. Must be ≥1.

Ports:
- `CLK`, in, 1: the only clock. All state updates on its rising edge.
- `RESET`, in, 1: synchronous, active-high.
- `READ`, in, 1: block read request. Driven by the cache's `MEM_MEM_READ`.
- `WRITE`, in, 1: block write request. Driven by the cache's `MEM_MEM_WRITE`.
- `BLOCK_ADDR`, in, 28: block address. Only `[IDX_BITS-1:0]` is used; upper bits are ignored, so blocks alias.
- `WRITE_DATA`, in, 128: block to store.
- `BUSYWAIT`, out, 1: request in progress. Feeds the cache's `MEM_BUSYWAIT`.
- `READ_DATA`, out, 128: last fetched block. Feeds the cache's `MEM_READ_OUT`.

## Operation
- Storage: `DEPTH_BLOCKS` × 128-bit array. `RESET` does not clear the array.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - If `WRITE` or `READ` is high at the rising edge: latch the operation, `BLOCK_ADDR[IDX_BITS-1:0]` and `WRITE_DATA`; load the counter with `LATENCY-1`; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; the latched copies are used.
  - If counter ≠ 0: decrement the counter.
  - If counter = 0:
    - Write: array[idx] <= latched data.
    - Read: `READ_DATA` <= array[idx].
    - Go to ACK.
- ACK:
  - Lasts exactly one cycle, then IDLE.
  - Requests seen in ACK are ignored. This is the cycle in which the requester observes completion and drops or changes its request.
- `WRITE` and `READ` both high at acceptance: the write wins, no read is performed, and `READ_DATA` is unchanged.
- `BUSYWAIT` is combinational: `BUSYWAIT = !RESET && ((state==IDLE && (READ||WRITE)) || state==BUSY)`.
  - It rises in the same cycle a request appears, so the cache never samples a false "done" on its first edge in a request state.
- `READ_DATA` is registered. It holds its value across writes and idle cycles and changes only on a read completion or reset.
- Back-to-back write-back then fetch:
  - The cache moves from write to read on the edge leaving ACK.
  - The memory is in IDLE in the next cycle, so `READ` raises `BUSYWAIT` immediately.
  - No extra gap is required.

## Timing
- Reset values: state IDLE, counter 0, `READ_DATA` = 0, `BUSYWAIT` = 0 while `RESET` is high.
- A request first seen at edge E (state IDLE):
  - Array access at edge E+`LATENCY`.
  - ACK during the cycle after E+`LATENCY`.
  - Back in IDLE at E+`LATENCY`+1.
- `BUSYWAIT` is high from the cycle the request is asserted through edge E+`LATENCY`, which is `LATENCY`+1 cycles including the pre-acceptance cycle. It is low in ACK.
- Read data is valid in `READ_DATA` from edge E+`LATENCY` onward, so it is stable when the cache samples it in its update state.
- `RESET` during BUSY aborts the access: no array write and no `READ_DATA` update; next state is IDLE. A request still held after reset is re-accepted from scratch on the first edge with `RESET` low.
- `RESET` during ACK: go to IDLE. The completed access stands.
- The counter is `IDX_BITS`-independent and sized to `$clog2(LATENCY)`, minimum 1 bit. It never underflows because the transition out of BUSY occurs at 0.

## Test plan
- Reset: hold `RESET` 2 cycles with `READ`=1 → `BUSYWAIT`=0, `READ_DATA`=0. Release → `BUSYWAIT`=1 immediately, and access completes 4 edges later.
- Write then read, `LATENCY`=4:
  - Write `0xDEADBEEF_01234567_89ABCDEF_CAFEBABE` to block 0x05 → `BUSYWAIT` high 5 cycles, then low 1 cycle.
  - Read block 0x05 → `READ_DATA` equals that value at the 4th edge after acceptance.
- Cache-style write-back then fetch: `WRITE` to 0x10, dropped and replaced by `READ` of 0x20 on the edge after ACK → `BUSYWAIT` continuously high except the single ACK cycle; read returns the pre-loaded block 0x20.
- Reset mid-write: assert `RESET` at the 2nd BUSY edge of a write to 0x07, then read 0x07 → old contents returned; new data not stored.
- Simultaneous `READ`+`WRITE` to 0x03 with data 0x1 → array[3]=0x1; `READ_DATA` keeps its prior value.
- Aliasing: write 0xAA.. to `BLOCK_ADDR`=0x0000105, then read 0x0000005 → returns 0xAA..; `BLOCK_ADDR` changes during BUSY have no effect.
